// File: rtl/pps_sync_ctrl_pkg.sv
// Shared types and defaults for the GPS PPS discipline controller.
package pps_sync_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ACQUIRE  = 2'd1,
      ST_LOCKED   = 2'd2,
      ST_HOLDOVER = 2'd3
   } state_t;

   localparam int unsigned DEF_CLK_HZ = 50_000_000;
   localparam int unsigned DEF_TOL    = 1000;

   // Free-running cycle counter that sticks at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/pps_sync_ctrl_if.sv
// Control/status bundle between the PPS controller and its user.
interface pps_sync_ctrl_if
   import pps_sync_ctrl_pkg::*;
();
   logic        en;
   logic        sig;
   logic        pe;
   logic        sec_tick;
   logic [31:0] period;
   logic        locked;
   logic        holdover;
   state_t      state;

   modport master (
      output en, sig,
      input  pe, sec_tick, period, locked, holdover, state
   );

   modport slave (
      input  en, sig,
      output pe, sec_tick, period, locked, holdover, state
   );
endinterface

// File: rtl/pps_sync_ctrl_edge.sv
// Two-flop synchroniser plus history flop; registered one-cycle rising-edge pulse.
module pps_edge (
   input  logic clk,
   input  logic rst,
   input  logic sig_i,
   output logic pe_o
);
   logic sync1_q, sync2_q, hist_q, pe_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         hist_q  <= 1'b0;
         pe_q    <= 1'b0;
      end else begin
         sync1_q <= sig_i;
         sync2_q <= sync1_q;
         hist_q  <= sync2_q;
         pe_q    <= sync2_q & ~hist_q;
      end
   end

   assign pe_o = pe_q;
endmodule

// File: rtl/pps_sync_ctrl.sv
// PPS discipline FSM: acquires lock on a GPS PPS input, emits a 1 Hz tick and
// free-runs in holdover for a bounded number of seconds when edges vanish.
module pps_sync_ctrl
   import pps_sync_ctrl_pkg::*;
#(
   parameter int unsigned CLK_HZ   = DEF_CLK_HZ,
   parameter int unsigned TOL      = DEF_TOL,
   parameter int unsigned LOCK_CNT = 3,
   parameter int unsigned MISS_MAX = 2
) (
   input  logic            clk,
   input  logic            rst,
   pps_sync_ctrl_if.slave  bus
);
   localparam logic [31:0] WIN_LO = 32'(CLK_HZ - TOL);
   localparam logic [31:0] WIN_HI = 32'(CLK_HZ + TOL);
   localparam logic [31:0] TOL_W  = 32'(TOL);
   localparam logic [31:0] LOCK_W = 32'(LOCK_CNT);
   localparam logic [31:0] MISS_W = 32'(MISS_MAX);

   state_t      state_q;
   logic [31:0] cnt_q, period_q, good_cnt_q, miss_cnt_q;
   logic        armed_q, tick_q, locked_q, holdover_q;
   logic        pe;
   logic [31:0] meas;
   logic        in_win, glitch, timeout, vtick, ho_late, ho_early;

   pps_edge u_edge (
      .clk   (clk),
      .rst   (rst),
      .sig_i (bus.sig),
      .pe_o  (pe)
   );

   always_comb begin
      meas     = sat_inc(cnt_q);
      in_win   = (meas >= WIN_LO) && (meas <= WIN_HI);
      glitch   = meas < WIN_LO;
      timeout  = cnt_q == period_q - 32'd1 + TOL_W;
      vtick    = cnt_q == period_q - 32'd1;
      ho_late  = meas >= period_q - TOL_W;
      ho_early = cnt_q < TOL_W;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         period_q   <= 32'(CLK_HZ);
         good_cnt_q <= '0;
         miss_cnt_q <= '0;
         armed_q    <= 1'b0;
         tick_q     <= 1'b0;
         locked_q   <= 1'b0;
         holdover_q <= 1'b0;
      end else begin
         tick_q <= 1'b0;
         cnt_q  <= meas;
         if (!bus.en) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            good_cnt_q <= '0;
            miss_cnt_q <= '0;
            armed_q    <= 1'b0;
            locked_q   <= 1'b0;
            holdover_q <= 1'b0;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  cnt_q   <= '0;
                  state_q <= ST_ACQUIRE;
               end
               ST_ACQUIRE: begin
                  if (pe) begin
                     cnt_q <= '0;
                     if (!armed_q) begin
                        armed_q <= 1'b1;
                     end else if (!in_win) begin
                        good_cnt_q <= '0;
                     end else if (good_cnt_q + 32'd1 == LOCK_W) begin
                        period_q   <= meas;
                        tick_q     <= 1'b1;
                        good_cnt_q <= '0;
                        miss_cnt_q <= '0;
                        locked_q   <= 1'b1;
                        state_q    <= ST_LOCKED;
                     end else begin
                        good_cnt_q <= good_cnt_q + 32'd1;
                     end
                  end
               end
               ST_LOCKED: begin
                  // A late edge still realigns phase but must not corrupt the period.
                  if (pe && !glitch) begin
                     cnt_q  <= '0;
                     tick_q <= 1'b1;
                     if (in_win) period_q <= meas;
                  end else if (timeout) begin
                     cnt_q      <= TOL_W;
                     tick_q     <= 1'b1;
                     miss_cnt_q <= 32'd1;
                     locked_q   <= 1'b0;
                     holdover_q <= 1'b1;
                     state_q    <= ST_HOLDOVER;
                  end
               end
               ST_HOLDOVER: begin
                  if (pe && (ho_late || ho_early)) begin
                     cnt_q      <= '0;
                     tick_q     <= ho_late;
                     miss_cnt_q <= '0;
                     locked_q   <= 1'b1;
                     holdover_q <= 1'b0;
                     state_q    <= ST_LOCKED;
                  end else if (vtick) begin
                     cnt_q  <= '0;
                     tick_q <= 1'b1;
                     if (miss_cnt_q + 32'd1 > MISS_W) begin
                        good_cnt_q <= '0;
                        miss_cnt_q <= '0;
                        holdover_q <= 1'b0;
                        state_q    <= ST_ACQUIRE;
                     end else begin
                        miss_cnt_q <= miss_cnt_q + 32'd1;
                     end
                  end
               end
            endcase
         end
      end
   end

   assign bus.pe       = pe;
   assign bus.sec_tick = tick_q;
   assign bus.period   = period_q;
   assign bus.locked   = locked_q;
   assign bus.holdover = holdover_q;
   assign bus.state    = state_q;
endmodule

// File: doc/pps_sync_ctrl.md
PPS_SYNC_CTRL -- requirements
Module: pps_sync_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, nominal clk cycles per PPS second.
REQ-002 Parameter TOL, default 1000, accepted period deviation in cycles (+/-).
REQ-003 Parameter LOCK_CNT, default 3, consecutive in-window periods required to lock.
REQ-004 Parameter MISS_MAX, default 2, holdover seconds allowed before lock is dropped.
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 en  in  1  enable; 0 forces IDLE.
REQ-008 sig  in  1  raw GPS PPS input, asynchronous to clk.
REQ-009 pe  out  1  one-cycle pulse on each synchronised rising edge of sig.
REQ-010 sec_tick  out  1  one-cycle disciplined 1 Hz tick.
REQ-011 period  out  32  last accepted PPS period in cycles.
REQ-012 locked  out  1  high in LOCKED.
REQ-013 holdover  out  1  high in HOLDOVER.
REQ-014 state  out  2  IDLE=0, ACQUIRE=1, LOCKED=2, HOLDOVER=3.

Function
REQ-015 sig SHALL pass a 2-flop synchroniser plus a history flop; pe = sync_out AND NOT history, high 3 cycles after the first clk edge sampling sig high.
REQ-016 Counter cnt (32 bit) SHALL load 0 in any cycle with an accepted pe or virtual tick, else increment, saturating at all-ones.
REQ-017 meas = cnt+1 SHALL be computed on each pe; in-window iff CLK_HZ-TOL <= meas <= CLK_HZ+TOL.
REQ-018 sec_tick SHALL be registered: high exactly one cycle after the qualifying pe or virtual-tick cycle.
REQ-019 IDLE: cnt, good_cnt, miss_cnt held 0; en=1 -> ACQUIRE next cycle.
REQ-020 ACQUIRE: first pe only restarts cnt; subsequent in-window pe increments good_cnt, out-of-window pe clears good_cnt and restarts cnt; no sec_tick.
REQ-021 ACQUIRE: pe that makes good_cnt == LOCK_CNT SHALL load period <= meas, issue sec_tick, enter LOCKED.
REQ-022 LOCKED: in-window pe -> period <= meas, sec_tick, cnt restart; pe with meas < CLK_HZ-TOL ignored as glitch (cnt not restarted).
REQ-023 LOCKED timeout: cnt == period-1+TOL with no pe -> sec_tick, cnt <= TOL, miss_cnt <= 1, enter HOLDOVER (restores virtual phase).
REQ-024 HOLDOVER: virtual tick when cnt == period-1 -> sec_tick, cnt <= 0, miss_cnt++; tick that makes miss_cnt > MISS_MAX still emits sec_tick, then enters ACQUIRE with good_cnt=0.
REQ-025 HOLDOVER: pe with cnt+1 >= period-TOL -> sec_tick, cnt <= 0, LOCKED; pe with cnt < TOL -> cnt <= 0, LOCKED, no extra sec_tick; other pe ignored.
REQ-026 pe coincident with timeout/virtual tick SHALL win (treated as real edge).
REQ-027 en falling in any state SHALL enter IDLE next cycle, no sec_tick; period retained.
REQ-028 At most one sec_tick per accepted edge or virtual tick; never two in consecutive cycles.

Reset
REQ-029 rst SHALL asynchronously force state=IDLE, pe=0, sec_tick=0, locked=0, holdover=0, period=CLK_HZ, cnt/good_cnt/miss_cnt=0, synchroniser flops=0.
REQ-030 rst asserted mid-second SHALL discard lock; after release the block behaves as from power-up.

Structure
REQ-031 Shared package SHALL hold state encoding constants and default CLK_HZ/TOL.
REQ-032 Edge detection SHALL be sub-module pps_edge (sig, clk, rst -> pe); remainder is one FSM plus counters.

Verification (sim params CLK_HZ=100, TOL=5, LOCK_CNT=3, MISS_MAX=2)
REQ-033 sig high at 105 ns, clk 20 ns -> pe one cycle, 3 clk edges after first high sample; no sec_tick.
REQ-034 Edges every 100 cycles x4 -> LOCKED on 4th edge, period=100, sec_tick one cycle after that pe.
REQ-035 Locked, edge spacing 103 then 96 -> both accepted, period=103 then 96; spacing 50 glitch -> ignored, state stays LOCKED.
REQ-036 Locked, edges stop -> HOLDOVER at cnt=104, ticks every 100 cycles, ACQUIRE after 3rd holdover tick.
REQ-037 HOLDOVER, edge 2 cycles after virtual tick -> LOCKED, no extra sec_tick.
REQ-038 rst pulse mid-LOCKED -> all outputs reset values immediately; en=0 -> IDLE next cycle.
